k_syncfifo_param: RTL and testbench



---
 rtl/k_syncfifo_param_if.sv | 29 ++
 rtl/k_syncfifo_param.sv | 85 ++++++++
 tb/tb_k_syncfifo_param.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/k_syncfifo_param_if.sv
// Handshake bundle for k_syncfifo_param: write port, show-ahead read port,
// flush, and occupancy/status outputs.
interface k_syncfifo_param_if #(
    parameter int data_size = 8,
    parameter int addr_size = 4
);
    logic                 flush;
    logic [data_size-1:0] wdata;
    logic                 wput;
    logic                 wrdy;
    logic [data_size-1:0] rdata;
    logic                 rrdy;
    logic                 rget;
    logic [addr_size:0]   count;
    logic                 afull;
    logic                 aempty;
    logic                 wovf;
    logic                 rudf;

    modport master (
        output flush, wdata, wput, rget,
        input  wrdy, rdata, rrdy, count, afull, aempty, wovf, rudf
    );

    modport slave (
        input  flush, wdata, wput, rget,
        output wrdy, rdata, rrdy, count, afull, aempty, wovf, rudf
    );
endinterface

// File: rtl/k_syncfifo_param.sv
// Single-clock FIFO with show-ahead read, registered occupancy count,
// programmable almost-full/almost-empty and sticky overflow/underflow flags.
module k_syncfifo_param #(
    parameter int data_size  = 8,
    parameter int addr_size  = 4,
    parameter int afull_lvl  = 12,
    parameter int aempty_lvl = 2
) (
    input  logic               clk,
    input  logic               rst,
    k_syncfifo_param_if.slave  bus
);
    localparam int depth = 1 << addr_size;
    localparam logic [addr_size:0] c_afull  = (addr_size+1)'(afull_lvl);
    localparam logic [addr_size:0] c_aempty = (addr_size+1)'(aempty_lvl);

    logic [data_size-1:0] r_mem [depth];
    logic [addr_size:0]   r_wptr;
    logic [addr_size:0]   r_rptr;
    logic [addr_size:0]   r_count;
    logic                 r_wovf;
    logic                 r_rudf;

    logic w_clr;
    logic w_full;
    logic w_empty;
    logic w_wr_en;
    logic w_rd_en;

    // rst and flush both gate off the handshakes so neither a write, a pop
    // nor an error flag can land in a clearing cycle.
    assign w_clr   = rst | bus.flush;
    assign w_full  = (r_wptr[addr_size] != r_rptr[addr_size]) &&
                     (r_wptr[addr_size-1:0] == r_rptr[addr_size-1:0]);
    assign w_empty = (r_wptr == r_rptr);
    assign w_wr_en = bus.wput & ~w_full  & ~w_clr;
    assign w_rd_en = bus.rget & ~w_empty & ~w_clr;

    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[r_wptr[addr_size-1:0]] <= bus.wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (w_clr) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_wr_en) r_wptr <= r_wptr + 1'b1;
            if (w_rd_en) r_rptr <= r_rptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_clr) begin
            r_count <= '0;
        end else begin
            case ({w_wr_en, w_rd_en})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_clr) begin
            r_wovf <= 1'b0;
            r_rudf <= 1'b0;
        end else begin
            if (bus.wput && w_full)  r_wovf <= 1'b1;
            if (bus.rget && w_empty) r_rudf <= 1'b1;
        end
    end

    assign bus.wrdy   = ~w_full;
    assign bus.rrdy   = ~w_empty;
    assign bus.rdata  = w_empty ? '0 : r_mem[r_rptr[addr_size-1:0]];
    assign bus.count  = r_count;
    assign bus.afull  = (r_count >= c_afull);
    assign bus.aempty = (r_count <= c_aempty);
    assign bus.wovf   = r_wovf;
    assign bus.rudf   = r_rudf;
endmodule

// File: tb/tb_k_syncfifo_param.sv
// Scoreboard bench for k_syncfifo_param at depth 4: stimulus pushes expected
// words, a negedge monitor pops and compares on every accepted read.
module tb_k_syncfifo_param;
    localparam int DW = 8;
    localparam int AW = 2;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   m_cnt   = 0;
    logic [DW-1:0] sb_q [$];

    k_syncfifo_param_if #(.data_size(DW), .addr_size(AW)) bus ();

    k_syncfifo_param #(
        .data_size (DW),
        .addr_size (AW),
        .afull_lvl (3),
        .aempty_lvl(1)
    ) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock: drive, let the edge happen, advance the reference model.
    task automatic step(input logic wp, input logic [DW-1:0] wd, input logic rg);
        bit wr_ok;
        bit rd_ok;
        bus.wput  = wp;
        bus.wdata = wd;
        bus.rget  = rg;
        @(posedge clk);
        if (rst || bus.flush) begin
            m_cnt = 0;
            sb_q.delete();
        end else begin
            wr_ok = wp && (m_cnt < DEPTH);
            rd_ok = rg && (m_cnt > 0);
            if (wr_ok) sb_q.push_back(wd);
            m_cnt = m_cnt + int'(wr_ok) - int'(rd_ok);
        end
        #1;
    endtask

    always @(negedge clk) begin
        if (!rst && !bus.flush) begin
            chk("rrdy_vs_model", int'(bus.rrdy), int'(m_cnt != 0));
            chk("wrdy_vs_model", int'(bus.wrdy), int'(m_cnt != DEPTH));
            if (m_cnt == 0) chk("rdata_when_empty", int'(bus.rdata), 0);
            if (bus.rget && m_cnt > 0) begin
                if (sb_q.size() == 0) begin
                    chk("scoreboard_nonempty", 0, 1);
                end else begin
                    chk("rdata_pop", int'(bus.rdata), int'(sb_q.pop_front()));
                end
            end
        end
    end

    initial begin
        bus.flush = 1'b0;
        bus.wput  = 1'b0;
        bus.wdata = '0;
        bus.rget  = 1'b0;

        // Reset state; handshakes during reset must be ignored.
        step(1'b1, 8'hFF, 1'b1);
        step(1'b0, 8'h00, 1'b0);
        rst = 1'b0;
        chk("rst_count",  int'(bus.count), 0);
        chk("rst_wrdy",   int'(bus.wrdy), 1);
        chk("rst_rrdy",   int'(bus.rrdy), 0);
        chk("rst_rdata",  int'(bus.rdata), 0);
        chk("rst_afull",  int'(bus.afull), 0);
        chk("rst_aempty", int'(bus.aempty), 1);
        chk("rst_wovf",   int'(bus.wovf), 0);
        chk("rst_rudf",   int'(bus.rudf), 0);

        // Fill: first word visible one cycle after its write.
        step(1'b1, 8'h11, 1'b0);
        chk("fill1_count", int'(bus.count), 1);
        chk("fill1_rdata", int'(bus.rdata), 'h11);
        chk("fill1_aempty", int'(bus.aempty), 1);
        step(1'b1, 8'h22, 1'b0);
        chk("fill2_aempty", int'(bus.aempty), 0);
        chk("fill2_afull", int'(bus.afull), 0);
        step(1'b1, 8'h33, 1'b0);
        chk("fill3_afull", int'(bus.afull), 1);
        chk("fill3_wrdy", int'(bus.wrdy), 1);
        step(1'b1, 8'h44, 1'b0);
        chk("full_wrdy",  int'(bus.wrdy), 0);
        chk("full_count", int'(bus.count), 4);
        chk("full_afull", int'(bus.afull), 1);
        chk("full_rdata", int'(bus.rdata), 'h11);
        chk("full_rrdy",  int'(bus.rrdy), 1);

        // Overflow attempt.
        step(1'b1, 8'h99, 1'b0);
        chk("ovf_wovf",  int'(bus.wovf), 1);
        chk("ovf_count", int'(bus.count), 4);
        chk("ovf_rdata", int'(bus.rdata), 'h11);

        // Drain with rget held five cycles; last one underflows.
        for (int i = 0; i < 4; i++) step(1'b0, 8'h00, 1'b1);
        chk("drain_count", int'(bus.count), 0);
        chk("drain_rudf_not_yet", int'(bus.rudf), 0);
        step(1'b0, 8'h00, 1'b1);
        chk("udf_rudf",   int'(bus.rudf), 1);
        chk("udf_rrdy",   int'(bus.rrdy), 0);
        chk("udf_rdata",  int'(bus.rdata), 0);
        chk("udf_aempty", int'(bus.aempty), 1);
        chk("udf_wovf_sticky", int'(bus.wovf), 1);

        rst = 1'b1;
        step(1'b0, 8'h00, 1'b0);
        rst = 1'b0;
        chk("rst2_wovf", int'(bus.wovf), 0);
        chk("rst2_rudf", int'(bus.rudf), 0);

        // Simultaneous put/get at count=2; pointers wrap several times.
        step(1'b1, 8'hA0, 1'b0);
        step(1'b1, 8'hA1, 1'b0);
        for (int i = 0; i < 20; i++) begin
            step(1'b1, 8'(8'hA2 + i), 1'b1);
            chk("simul_count", int'(bus.count), 2);
        end
        step(1'b0, 8'h00, 1'b1);
        step(1'b0, 8'h00, 1'b1);
        chk("simul_end_count", int'(bus.count), 0);
        chk("simul_wovf", int'(bus.wovf), 0);
        chk("simul_rudf", int'(bus.rudf), 0);

        // Write to empty with rget high: only the write lands, rudf sets.
        step(1'b1, 8'h5C, 1'b1);
        chk("wempty_rudf",  int'(bus.rudf), 1);
        chk("wempty_count", int'(bus.count), 1);
        chk("wempty_rrdy",  int'(bus.rrdy), 1);
        chk("wempty_rdata", int'(bus.rdata), 'h5C);
        step(1'b0, 8'h00, 1'b1);
        chk("wempty_pop_count", int'(bus.count), 0);

        // Flush at count=3 with wovf set; handshakes in the flush cycle ignored.
        for (int i = 0; i < 4; i++) step(1'b1, 8'(8'hB1 + i), 1'b0);
        step(1'b1, 8'hEE, 1'b0);
        step(1'b0, 8'h00, 1'b1);
        chk("preflush_count", int'(bus.count), 3);
        chk("preflush_wovf",  int'(bus.wovf), 1);
        chk("preflush_rdata", int'(bus.rdata), 'hB2);
        bus.flush = 1'b1;
        step(1'b1, 8'h77, 1'b1);
        bus.flush = 1'b0;
        chk("flush_count", int'(bus.count), 0);
        chk("flush_rrdy",  int'(bus.rrdy), 0);
        chk("flush_wrdy",  int'(bus.wrdy), 1);
        chk("flush_wovf",  int'(bus.wovf), 0);
        chk("flush_rudf",  int'(bus.rudf), 0);
        chk("flush_rdata", int'(bus.rdata), 0);
        step(1'b1, 8'h5A, 1'b0);
        chk("postflush_rdata", int'(bus.rdata), 'h5A);
        chk("postflush_count", int'(bus.count), 1);
        step(1'b0, 8'h00, 1'b1);
        step(1'b0, 8'h00, 1'b0);
        chk("final_count", int'(bus.count), 0);
        chk("final_sb_empty", sb_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
